mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the number of implemented word-address bits (256 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the number of BUSY cycles per access (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rd_mem, input, 1 bit: read request from the write-back stage.
REQ-006 SHALL have port wr_mem, input, 1 bit: write request from the write-back stage.
REQ-007 SHALL have port mem_addr, input, 16 bits: word address.
REQ-008 SHALL have port mem_data, input, 16 bits: write data.
REQ-009 SHALL have port rd_data, output, 16 bits: read result, valid while done is high.
REQ-010 SHALL have port busy, output, 1 bit: high while a transaction is in progress; requests are not accepted.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: error flag, valid while done is high.

Function
REQ-013 SHALL use FSM states IDLE, BUSY and DONE.
REQ-014 SHALL accept a request only in IDLE with (rd_mem | wr_mem) = 1; it registers addr, data, op and error status, then goes to BUSY (or to DONE if WAIT_CYCLES = 0).
REQ-015 SHALL keep a wait counter in BUSY: load WAIT_CYCLES-1 on accept, decrement each cycle, and move to DONE on the cycle it reads 0.
REQ-016 SHALL give a total latency of WAIT_CYCLES+1 cycles from the accepting edge to the done pulse; done is high for exactly one cycle (state DONE), then the FSM returns to IDLE.
REQ-017 SHALL drive busy = 1 in BUSY and DONE, and 0 in IDLE.
REQ-018 SHALL, when rd_mem and wr_mem are both 1 at accept, perform a write and set err = 1 at done.
REQ-019 SHALL treat mem_addr[15:ADDR_BITS] != 0 as out of range: no array access, rd_data = 0 and err = 1 at done.
REQ-020 SHALL commit a write to the array on the edge entering DONE.
REQ-021 SHALL sample read data from the array on that same edge into the rd_data register.
REQ-022 SHALL hold rd_data stable until the next done; it is 0 at done for writes.
REQ-023 SHALL make read-after-write to the same address in back-to-back transactions return the new data.
REQ-024 SHALL ignore request inputs while in BUSY or DONE; the initiator drops its request in the cycle after done, and a request still high in IDLE is a new transaction.
REQ-025 SHALL use only mem_addr[ADDR_BITS-1:0] to index the array.
REQ-026 SHALL drive err = 0 whenever done = 0.

Reset
REQ-027 SHALL, while rst_n = 0 at a clock edge, set the state to IDLE, the counter to 0, and rd_data, busy, done and err to 0.
REQ-028 SHALL NOT reset the array contents.
REQ-029 SHALL abort any transaction in flight when reset is asserted mid-operation; a pending write is not committed and no done is generated.

Structure
REQ-030 SHALL place WORD_W = 16, the FSM state encoding and the op encoding (OP_RD, OP_WR) in the shared package risc_pkg.
REQ-031 SHALL hold the storage in sub-module mem_array: a single-port synchronous RAM of 2^ADDR_BITS x WORD_W with we, addr, wdata and rdata.

Verification
REQ-032 Write then read, WAIT_CYCLES = 2: wr_mem with addr 0x0010 and data 0xBEEF -> done at accept+3, err = 0. Then rd_mem with addr 0x0010 -> done at accept+3 with rd_data = 0xBEEF.
REQ-033 WAIT_CYCLES = 0: rd_mem to a written address -> done on the cycle after accept, and busy is high for exactly one cycle.
REQ-034 Both rd_mem and wr_mem high, addr 0x0005, data 0x1234 -> err = 1 at done. A following read of 0x0005 returns 0x1234.
REQ-035 Out-of-range addr 0x0100 with wr_mem and data 0xFFFF -> err = 1 and rd_data = 0. A following read of 0x0000 is unchanged.
REQ-036 Requests toggled while busy = 1 -> ignored: no extra done pulses and the array is unchanged.
REQ-037 Reset mid-BUSY during a write to 0x0020 -> busy, done and err go to 0 on the next edge, no done pulse occurs, and a later read of 0x0020 returns the old data.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared word width, FSM state encoding and operation encoding for the
// memory-side blocks of the write-back stage.
package risc_pkg;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;
endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read of the
// addressed word so the responder can register it on the commit edge.
module mem_array
    import risc_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    // NOTE: storage has no reset; contents must survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one request in IDLE, stalls for
// WAIT_CYCLES, then commits/reads the array and pulses done for one cycle.
module mem_responder
    import risc_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_data,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t               state;
    op_t                  op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_W-1:0]    data_q;
    logic                 oor_q;
    logic                 err_q;
    logic [3:0]           cnt;

    logic                 req;
    logic                 in_oor;
    logic                 commit;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [WORD_W-1:0]    cur_data;
    logic                 cur_wr;
    logic                 cur_oor;
    logic                 cur_err;
    logic                 ram_we;
    logic [WORD_W-1:0]    ram_rdata;

    assign req    = rd_mem | wr_mem;
    assign in_oor = (mem_addr >> ADDR_BITS) != 16'd0;

    // With zero wait states the accepting edge is also the commit edge, so the
    // array is fed straight from the request inputs while in IDLE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_addr = addr_q;
        cur_data = data_q;
        cur_wr   = (op_q == OP_WR);
        cur_oor  = oor_q;
        cur_err  = err_q;
        commit   = (state == BUSY) && (cnt == 4'd0);
        if (state == IDLE) begin
            cur_addr = mem_addr[ADDR_BITS-1:0];
            cur_data = mem_data;
            cur_wr   = wr_mem;
            cur_oor  = in_oor;
            cur_err  = in_oor | (rd_mem & wr_mem);
            commit   = req && (WAIT_CYCLES == 0);
        end
    end

    assign ram_we = commit & cur_wr & ~cur_oor;

    mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_addr),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= commit;
            err  <= commit & cur_err;
            if (commit) begin
                rd_data <= (cur_wr | cur_oor) ? '0 : ram_rdata;
            end
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= mem_addr[ADDR_BITS-1:0];
                        data_q <= mem_data;
                        op_q   <= wr_mem ? OP_WR : OP_RD;
                        oor_q  <= in_oor;
                        err_q  <= in_oor | (rd_mem & wr_mem);
                        cnt    <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= (WAIT_CYCLES == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with zero wait states, sharing clock, reset, address and data.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd0, wr0, rd1, wr1;
    logic [15:0] addr, data;
    logic [15:0] rdata0, rdata1;
    logic        busy0, done0, err0, busy1, done1, err1;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_mem(rd0), .wr_mem(wr0), .mem_addr(addr),
        .mem_data(data), .rd_data(rdata0), .busy(busy0), .done(done0), .err(err0)
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_mem(rd1), .wr_mem(wr1), .mem_addr(addr),
        .mem_data(data), .rd_data(rdata1), .busy(busy1), .done(done1), .err(err1)
    );

    // Drive one request, then count cycles after the accepting edge until done.
    // cycles stays 0 if done never arrives within the budget.
    task automatic run_txn(input bit sel, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d,
                           output int cycles, output int busy_cycles,
                           output logic [15:0] rd_q, output logic err_q);
        @(negedge clk);
        addr = a;
        data = d;
        if (sel) begin rd1 = rd; wr1 = wr; end
        else     begin rd0 = rd; wr0 = wr; end
        @(posedge clk);
        cycles      = 0;
        busy_cycles = 0;
        rd_q        = '0;
        err_q       = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0; end
            if (sel ? busy1 : busy0) busy_cycles++;
            if (sel ? done1 : done0) begin
                cycles = n;
                rd_q   = sel ? rdata1 : rdata0;
                err_q  = sel ? err1 : err0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy0 !== 1'b0)    begin failures++; $display("FAIL rst_busy0 got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0)    begin failures++; $display("FAIL rst_done0 got %b want 0", done0); end
        checks++; if (err0 !== 1'b0)     begin failures++; $display("FAIL rst_err0 got %b want 0", err0); end
        checks++; if (rdata0 !== 16'h0)  begin failures++; $display("FAIL rst_rdata0 got %h want 0000", rdata0); end
        checks++; if (busy1 !== 1'b0)    begin failures++; $display("FAIL rst_busy1 got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0)    begin failures++; $display("FAIL rst_done1 got %b want 0", done1); end
        checks++; if (err1 !== 1'b0)     begin failures++; $display("FAIL rst_err1 got %b want 0", err1); end
        checks++; if (rdata1 !== 16'h0)  begin failures++; $display("FAIL rst_rdata1 got %h want 0000", rdata1); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int cyc, bc; logic [15:0] r; logic e;
        run_txn(0, 0, 1, 16'h0010, 16'hBEEF, cyc, bc, r, e);
        checks++; if (cyc !== 3)        begin failures++; $display("FAIL wr_latency got %0d want 3", cyc); end
        checks++; if (e !== 1'b0)       begin failures++; $display("FAIL wr_err got %b want 0", e); end
        checks++; if (r !== 16'h0)      begin failures++; $display("FAIL wr_rdata got %h want 0000", r); end
        run_txn(0, 1, 0, 16'h0010, 16'h0000, cyc, bc, r, e);
        checks++; if (cyc !== 3)        begin failures++; $display("FAIL rd_latency got %0d want 3", cyc); end
        checks++; if (bc !== 3)         begin failures++; $display("FAIL rd_busy_cycles got %0d want 3", bc); end
        checks++; if (r !== 16'hBEEF)   begin failures++; $display("FAIL rd_data got %h want beef", r); end
        checks++; if (e !== 1'b0)       begin failures++; $display("FAIL rd_err got %b want 0", e); end
        @(negedge clk);
        checks++; if (done0 !== 1'b0)   begin failures++; $display("FAIL done_one_cycle got %b want 0", done0); end
        checks++; if (err0 !== 1'b0)    begin failures++; $display("FAIL err_after_done got %b want 0", err0); end
        checks++; if (rdata0 !== 16'hBEEF) begin failures++; $display("FAIL rdata_hold got %h want beef", rdata0); end
    endtask

    task automatic test_zero_wait();
        int cyc, bc; logic [15:0] r; logic e;
        run_txn(1, 0, 1, 16'h0033, 16'h5A5A, cyc, bc, r, e);
        checks++; if (cyc !== 1)        begin failures++; $display("FAIL z_wr_latency got %0d want 1", cyc); end
        run_txn(1, 1, 0, 16'h0033, 16'h0000, cyc, bc, r, e);
        checks++; if (cyc !== 1)        begin failures++; $display("FAIL z_rd_latency got %0d want 1", cyc); end
        checks++; if (bc !== 1)         begin failures++; $display("FAIL z_busy_cycles got %0d want 1", bc); end
        checks++; if (r !== 16'h5A5A)   begin failures++; $display("FAIL z_rd_data got %h want 5a5a", r); end
        @(negedge clk);
        checks++; if (busy1 !== 1'b0)   begin failures++; $display("FAIL z_busy_after got %b want 0", busy1); end
    endtask

    task automatic test_both_ops();
        int cyc, bc; logic [15:0] r; logic e;
        run_txn(0, 1, 1, 16'h0005, 16'h1234, cyc, bc, r, e);
        checks++; if (cyc !== 3)        begin failures++; $display("FAIL both_latency got %0d want 3", cyc); end
        checks++; if (e !== 1'b1)       begin failures++; $display("FAIL both_err got %b want 1", e); end
        checks++; if (r !== 16'h0)      begin failures++; $display("FAIL both_rdata got %h want 0000", r); end
        run_txn(0, 1, 0, 16'h0005, 16'h0000, cyc, bc, r, e);
        checks++; if (r !== 16'h1234)   begin failures++; $display("FAIL both_readback got %h want 1234", r); end
        checks++; if (e !== 1'b0)       begin failures++; $display("FAIL both_readback_err got %b want 0", e); end
    endtask

    task automatic test_out_of_range();
        int cyc, bc; logic [15:0] r; logic e;
        run_txn(0, 0, 1, 16'h0000, 16'h0C0C, cyc, bc, r, e);
        run_txn(0, 0, 1, 16'h0100, 16'hFFFF, cyc, bc, r, e);
        checks++; if (cyc !== 3)        begin failures++; $display("FAIL oor_latency got %0d want 3", cyc); end
        checks++; if (e !== 1'b1)       begin failures++; $display("FAIL oor_err got %b want 1", e); end
        checks++; if (r !== 16'h0)      begin failures++; $display("FAIL oor_rdata got %h want 0000", r); end
        run_txn(0, 1, 0, 16'h0000, 16'h0000, cyc, bc, r, e);
        checks++; if (r !== 16'h0C0C)   begin failures++; $display("FAIL oor_alias got %h want 0c0c", r); end
        run_txn(0, 1, 0, 16'h8000, 16'h0000, cyc, bc, r, e);
        checks++; if (e !== 1'b1)       begin failures++; $display("FAIL oor_rd_err got %b want 1", e); end
        checks++; if (r !== 16'h0)      begin failures++; $display("FAIL oor_rd_data got %h want 0000", r); end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc, dones; logic [15:0] r, cap; logic e;
        run_txn(0, 0, 1, 16'h0040, 16'h1111, cyc, bc, r, e);
        @(negedge clk);
        addr = 16'h0040;
        rd0  = 1'b1;
        @(posedge clk);
        dones = 0;
        cap   = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            case (n)
                1: begin rd0 = 0; wr0 = 1; data = 16'h2222; end
                2: begin wr0 = 0; rd0 = 1; end
                3: rd0 = 0;
                default: ;
            endcase
            if (done0) begin dones++; cap = rdata0; end
        end
        checks++; if (dones !== 1)      begin failures++; $display("FAIL ignore_dones got %0d want 1", dones); end
        checks++; if (cap !== 16'h1111) begin failures++; $display("FAIL ignore_rdata got %h want 1111", cap); end
        run_txn(0, 1, 0, 16'h0040, 16'h0000, cyc, bc, r, e);
        checks++; if (r !== 16'h1111)   begin failures++; $display("FAIL ignore_array got %h want 1111", r); end
    endtask

    task automatic test_reset_mid();
        int cyc, bc, dones; logic [15:0] r; logic e;
        run_txn(0, 0, 1, 16'h0020, 16'hAAAA, cyc, bc, r, e);
        @(negedge clk);
        addr = 16'h0020;
        data = 16'h5555;
        wr0  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr0   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0)   begin failures++; $display("FAIL abort_busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0)   begin failures++; $display("FAIL abort_done got %b want 0", done0); end
        checks++; if (err0 !== 1'b0)    begin failures++; $display("FAIL abort_err got %b want 0", err0); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done0) dones++;
        end
        checks++; if (dones !== 0)      begin failures++; $display("FAIL abort_no_done got %0d want 0", dones); end
        run_txn(0, 1, 0, 16'h0020, 16'h0000, cyc, bc, r, e);
        checks++; if (r !== 16'hAAAA)   begin failures++; $display("FAIL abort_old_data got %h want aaaa", r); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; logic [15:0] r; logic e;
        run_txn(0, 0, 1, 16'h0077, 16'h0F0F, cyc, bc, r, e);
        run_txn(0, 1, 0, 16'h0077, 16'h0000, cyc, bc, r, e);
        checks++; if (r !== 16'h0F0F)   begin failures++; $display("FAIL b2b_raw got %h want 0f0f", r); end
        checks++; if (cyc !== 3)        begin failures++; $display("FAIL b2b_latency got %0d want 3", cyc); end
    endtask

    initial begin
        rst_n = 1'b0;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        addr = '0;
        data = '0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_both_ops();
        test_out_of_range();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
